lm07_poll_sched: RTL
====================

Name: lm07_poll_sched

Overview:
Periodic poll scheduler for the LM07 SPI temperature reader. It issues a one-cycle start to the reader at a fixed start-to-start interval and supervises completion with a timeout. It latches each signed 8-bit reading and tracks min/max. It drives an over-temperature alarm with hysteresis. It sits between the reader (which owns CS/SCK/SIO) and the display/system logic.

Parameters:
PERIOD_CYC, 1000, SYSCLK cycles from one rd_start to the next; must be >= TIMEOUT_CYC+3.
TIMEOUT_CYC, 200, max cycles spent in WAIT_DONE before a timeout is declared; >= 1.
CW, 16, width of the period and timeout counters; must hold PERIOD_CYC-1.
T_HIGH, 8'sd50, alarm set threshold, signed degrees C.
T_HYST, 8'sd5, hysteresis; alarm clear threshold is T_HIGH-T_HYST, computed signed in 9 bits.

Ports:
SYSCLK  in  1  system clock; all logic on rising edge.
RST  in  1  synchronous, active-high reset.
enable  in  1  1 = run polling; 0 = stop after the current transaction.
clr_minmax  in  1  one-cycle pulse that invalidates min/max tracking.
rd_start  out  1  one-cycle start pulse to the reader.
rd_done  in  1  one-cycle completion pulse from the reader.
rd_data  in  8  reader result, two's complement; valid only when rd_done=1.
temp  out  8  last good reading, signed.
temp_valid  out  1  one-cycle pulse when temp updates.
temp_min  out  8  minimum reading since reset or clr_minmax, signed.
temp_max  out  8  maximum reading since reset or clr_minmax, signed.
minmax_valid  out  1  1 once min/max hold at least one sample.
alarm  out  1  over-temperature flag.
timeout_err  out  1  sticky; set on timeout, cleared by the next good read.
err_cnt  out  8  saturating timeout count (stops at 255).
busy  out  1  1 in states START, WAIT_DONE, UPDATE.

Behaviour:
- Reset (RST=1 at an edge): state IDLE, both counters 0, all outputs 0. Reset mid-transaction abandons it and rd_start stays 0; the reader has its own reset.
- FSM states: IDLE, START, WAIT_DONE, UPDATE, WAIT_PERIOD.
- IDLE: if enable=1, go to START on the next edge. The first start occurs 1 cycle after enable rises.
- START:
  - rd_start=1 for exactly this cycle.
  - Period counter loads 0; timeout counter loads 0.
  - Next state is WAIT_DONE.
- Period counter increments every cycle outside START and IDLE, saturating at PERIOD_CYC-1.
- WAIT_DONE:
  - rd_done=1: capture rd_data, go to UPDATE.
  - Otherwise, if timeout counter = TIMEOUT_CYC-1: set timeout_err, err_cnt += 1 (saturating), go to WAIT_PERIOD. temp, min/max and alarm are unchanged.
  - Otherwise increment the timeout counter.
  - If rd_done and timeout coincide in the same cycle, rd_done wins.
- UPDATE (one cycle):
  - temp <= captured value; temp_valid=1; timeout_err <= 0.
  - Min/max: if minmax_valid=0 or clr_minmax=1 this cycle, min=max=sample and minmax_valid <= 1. Otherwise min/max update by signed compare.
  - Alarm: set if sample > T_HIGH (signed); clear if sample < T_HIGH-T_HYST; else hold.
  - Next state is WAIT_PERIOD.
- WAIT_PERIOD:
  - enable=0: go to IDLE.
  - Else if period counter = PERIOD_CYC-1: go to START. This gives start-to-start spacing of exactly PERIOD_CYC cycles.
- clr_minmax outside UPDATE: minmax_valid <= 0 on the next edge; temp_min/temp_max keep their old values until the next sample.
- enable=0 during START, WAIT_DONE or UPDATE: the transaction completes normally, then the block goes WAIT_PERIOD -> IDLE. A transaction is never aborted by enable.
- rd_done outside WAIT_DONE is ignored; no state or output changes.
- temp_valid and rd_start are never high in the same cycle.

Test Plan:
(Parameters for all scenarios: PERIOD_CYC=20, TIMEOUT_CYC=8, T_HIGH=50, T_HYST=5; the reader model returns rd_done 4 cycles after rd_start.)
1. Release RST, enable=1, reader returns 8'd25 -> rd_start at cycles t, t+20, t+40; temp_valid 5 cycles after each rd_start; temp=25, min=max=25, alarm=0.
2. Reader returns 40, 51, 48, 44, 46 -> alarm sets at 51, holds at 48, clears at 44, stays 0 at 46; min=40, max=51.
3. Reader returns 8'hF6 then 8'd3 -> temp_min=-10 (8'hF6), temp_max=3 (signed compare verified).
4. Reader never returns rd_done -> timeout_err=1 after 8 cycles in WAIT_DONE, err_cnt=1; next rd_start still 20 cycles after the previous; a later good read clears timeout_err with err_cnt=1 retained. Also: rd_done on the exact timeout cycle -> sample accepted, no error.
5. Deassert enable in the cycle after rd_start -> read completes with temp_valid, block reaches IDLE, no further rd_start; re-enable -> rd_start 1 cycle later. Also: clr_minmax coinciding with UPDATE -> min=max=new sample.
6. Assert RST during WAIT_DONE -> all outputs 0 next cycle, IDLE; a stray rd_done afterwards is ignored.

Source files
------------

// File: rtl/lm07_poll_sched_if.sv
// rtl/lm07_poll_sched_if.sv - start/done/data handshake between poll scheduler and LM07 reader
interface lm07_poll_sched_if;
  logic       rd_start;
  logic       rd_done;
  logic [7:0] rd_data;

  modport master (output rd_start, input rd_done, input rd_data);
  modport slave  (input rd_start, output rd_done, output rd_data);
endinterface

// File: rtl/lm07_poll_sched.sv
// rtl/lm07_poll_sched.sv - periodic LM07 poll scheduler with timeout supervision,
// min/max tracking and a hysteresis over-temperature alarm
module lm07_poll_sched #(
  parameter int unsigned       PERIOD_CYC  = 1000,
  parameter int unsigned       TIMEOUT_CYC = 200,
  parameter int unsigned       CW          = 16,
  parameter logic signed [7:0] T_HIGH      = 8'sd50,
  parameter logic signed [7:0] T_HYST      = 8'sd5
) (
  input  logic              SYSCLK,
  input  logic              RST,
  input  logic              enable,
  input  logic              clr_minmax,
  lm07_poll_sched_if.master rd,
  output logic [7:0]        temp,
  output logic              temp_valid,
  output logic [7:0]        temp_min,
  output logic [7:0]        temp_max,
  output logic              minmax_valid,
  output logic              alarm,
  output logic              timeout_err,
  output logic [7:0]        err_cnt,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, START, WAIT_DONE, UPDATE, WAIT_PERIOD} state_t;

  localparam logic [CW-1:0]     PER_LAST = CW'(PERIOD_CYC - 1);
  localparam logic [CW-1:0]     TO_LAST  = CW'(TIMEOUT_CYC - 1);
  localparam logic signed [8:0] T_SET    = {T_HIGH[7], T_HIGH};
  localparam logic signed [8:0] T_CLR    = T_SET - {T_HYST[7], T_HYST};

  state_t          state_q, state_d;
  logic [CW-1:0]   per_q, per_d;
  logic [CW-1:0]   to_q, to_d;
  logic [7:0]      cap_q, cap_d;
  logic [7:0]      temp_q, temp_d;
  logic [7:0]      min_q, min_d;
  logic [7:0]      max_q, max_d;
  logic            mmv_q, mmv_d;
  logic            alarm_q, alarm_d;
  logic            terr_q, terr_d;
  logic [7:0]      ecnt_q, ecnt_d;
  logic signed [8:0] smp;

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    to_d    = to_q;
    cap_d   = cap_q;
    temp_d  = temp_q;
    min_d   = min_q;
    max_d   = max_q;
    mmv_d   = mmv_q;
    alarm_d = alarm_q;
    terr_d  = terr_q;
    ecnt_d  = ecnt_q;
    smp     = {cap_q[7], cap_q};

    if (state_q != IDLE && per_q != PER_LAST) per_d = per_q + CW'(1);
    if (clr_minmax) mmv_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable) state_d = START;
      end
      START: begin
        to_d    = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (rd.rd_done) begin
          cap_d   = rd.rd_data;
          state_d = UPDATE;
        end else if (to_q == TO_LAST) begin
          terr_d  = 1'b1;
          if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
          state_d = WAIT_PERIOD;
        end else begin
          to_d = to_q + CW'(1);
        end
      end
      UPDATE: begin
        temp_d = cap_q;
        terr_d = 1'b0;
        if (!mmv_q || clr_minmax) begin
          min_d = cap_q;
          max_d = cap_q;
        end else begin
          if ($signed(cap_q) < $signed(min_q)) min_d = cap_q;
          if ($signed(cap_q) > $signed(max_q)) max_d = cap_q;
        end
        mmv_d = 1'b1;
        if (smp > T_SET)      alarm_d = 1'b1;
        else if (smp < T_CLR) alarm_d = 1'b0;
        state_d = WAIT_PERIOD;
      end
      WAIT_PERIOD: begin
        if (!enable)              state_d = IDLE;
        else if (per_q == PER_LAST) state_d = START;
      end
      default: state_d = IDLE;
    endcase

    // The counter holds 0 during START itself, so starts land exactly PERIOD_CYC apart.
    if (state_d == START) per_d = '0;
  end

  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state_q <= IDLE;
      per_q   <= '0;
      to_q    <= '0;
      cap_q   <= '0;
      temp_q  <= '0;
      min_q   <= '0;
      max_q   <= '0;
      mmv_q   <= 1'b0;
      alarm_q <= 1'b0;
      terr_q  <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      to_q    <= to_d;
      cap_q   <= cap_d;
      temp_q  <= temp_d;
      min_q   <= min_d;
      max_q   <= max_d;
      mmv_q   <= mmv_d;
      alarm_q <= alarm_d;
      terr_q  <= terr_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign rd.rd_start   = (state_q == START);
  assign temp_valid    = (state_q == UPDATE);
  assign busy          = (state_q == START) || (state_q == WAIT_DONE) || (state_q == UPDATE);
  assign temp          = temp_q;
  assign temp_min      = min_q;
  assign temp_max      = max_q;
  assign minmax_valid  = mmv_q;
  assign alarm         = alarm_q;
  assign timeout_err   = terr_q;
  assign err_cnt       = ecnt_q;

endmodule
